// File: rtl/loopback_prbs_checker.sv
// Purpose : PRBS-7 loopback generator/checker; self-syncs to the returned stream, counts bits/errors, reports lock.
// Latency : lock rises 7+LOCK_N+1 enabled cycles after start on a clean stream; err_cnt moves 1 cycle after a bad rx sample.
// Backpr. : none; en low pauses every register (tx stream, checker, counters), rst overrides en.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   en                global enable; low freezes all state
//   start             run request, honoured only in IDLE or DONE
//   clear             zero err_cnt/bit_cnt (wins over a same-cycle count)
//   rx_bit            returned loopback bit
//   tx_bit            registered PRBS-7 output
//   lock / done       state decodes (LOCKED / DONE)
//   err_cnt, bit_cnt  saturating error count / checked-bit count while locked
module loopback_prbs_checker #(
   parameter int LOCK_N   = 32,
   parameter int UNLOCK_N = 8,
   parameter int NBITS    = 100000,
   parameter int CNT_W    = 24,
   parameter int ERR_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             start,
   input  logic             clear,
   input  logic             rx_bit,
   output logic             tx_bit,
   output logic             lock,
   output logic             done,
   output logic [ERR_W-1:0] err_cnt,
   output logic [CNT_W-1:0] bit_cnt
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEED,
      ST_HUNT,
      ST_LOCKED,
      ST_DONE
   } state_t;

   localparam logic [7:0]       LOCK_N_C   = 8'(LOCK_N);
   localparam logic [6:0]       UNLOCK_N_C = 7'(UNLOCK_N);
   localparam logic [CNT_W-1:0] NBITS_C    = CNT_W'(NBITS);
   localparam logic [CNT_W-1:0] BIT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [ERR_W-1:0] ERR_ONE    = {{(ERR_W-1){1'b0}}, 1'b1};

   state_t           state, state_nxt;
   logic [6:0]       txl;
   logic [6:0]       chk, chk_nxt;
   logic [2:0]       seed_cnt, seed_cnt_nxt;
   logic [7:0]       good, good_nxt;
   logic [5:0]       win_cnt, win_cnt_nxt;
   logic [6:0]       win_err, win_err_nxt;
   logic [ERR_W-1:0] err_nxt;
   logic [CNT_W-1:0] bits_nxt;

   logic             pred;
   logic             rx_err;
   logic [6:0]       win_err_inc;
   logic [CNT_W-1:0] bit_cnt_inc;

   // chk holds the last 7 bits, oldest in bit 6; x^7+x^6+1 recurrence.
   assign pred        = chk[6] ^ chk[5];
   assign rx_err      = rx_bit ^ pred;
   assign win_err_inc = win_err + {6'd0, rx_err};
   assign bit_cnt_inc = bit_cnt + BIT_ONE;
   assign tx_bit      = txl[6];

   always_comb begin
      state_nxt    = state;
      chk_nxt      = chk;
      seed_cnt_nxt = seed_cnt;
      good_nxt     = good;
      win_cnt_nxt  = win_cnt;
      win_err_nxt  = win_err;
      err_nxt      = err_cnt;
      bits_nxt     = bit_cnt;
      lock         = (state == ST_LOCKED);
      done         = (state == ST_DONE);

      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_nxt    = ST_SEED;
               seed_cnt_nxt = 3'd0;
               err_nxt      = '0;
               bits_nxt     = '0;
            end
         end
         ST_SEED: begin
            chk_nxt      = {chk[5:0], rx_bit};
            seed_cnt_nxt = seed_cnt + 3'd1;
            if (seed_cnt == 3'd6) begin
               state_nxt = ST_HUNT;
               good_nxt  = 8'd0;
            end
         end
         ST_HUNT: begin
            chk_nxt = {chk[5:0], rx_bit};
            // Lock is declared the cycle after the run completes; that cycle's bit is not judged.
            if (good == LOCK_N_C) begin
               state_nxt   = ST_LOCKED;
               win_cnt_nxt = 6'd0;
               win_err_nxt = 7'd0;
            end else if (!rx_err && (chk != 7'd0)) begin
               good_nxt = good + 8'd1;
            end else begin
               good_nxt = 8'd0;
            end
         end
         ST_LOCKED: begin
            // Free-run the predictor so a single flipped rx bit costs exactly one error.
            chk_nxt     = {chk[5:0], pred};
            bits_nxt    = bit_cnt_inc;
            if (rx_err && (err_cnt != '1))
               err_nxt = err_cnt + ERR_ONE;
            win_cnt_nxt = win_cnt + 6'd1;
            // The 64th bit still belongs to the closing window for the unlock test.
            win_err_nxt = (win_cnt == 6'd63) ? 7'd0 : win_err_inc;
            if (bit_cnt_inc == NBITS_C) begin
               state_nxt = ST_DONE;
            end else if (win_err_inc >= UNLOCK_N_C) begin
               state_nxt = ST_HUNT;
               good_nxt  = 8'd0;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      if (clear) begin
         err_nxt  = '0;
         bits_nxt = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         txl      <= 7'h7F;
         chk      <= 7'd0;
         seed_cnt <= 3'd0;
         good     <= 8'd0;
         win_cnt  <= 6'd0;
         win_err  <= 7'd0;
         err_cnt  <= '0;
         bit_cnt  <= '0;
      end else if (en) begin
         state    <= state_nxt;
         txl      <= {txl[5:0], txl[6] ^ txl[5]};
         chk      <= chk_nxt;
         seed_cnt <= seed_cnt_nxt;
         good     <= good_nxt;
         win_cnt  <= win_cnt_nxt;
         win_err  <= win_err_nxt;
         err_cnt  <= err_nxt;
         bit_cnt  <= bits_nxt;
      end
   end

endmodule
